// File: rtl/latch_monitor.sv
// latch_monitor - reference-model checker for the SR/JK/D latch block.
// Samples a/b, delays the expected state by SETTLE_CYC cycles and counts divergences.
module latch_monitor #(
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic             clear,
  input  logic             a,
  input  logic             b,
  input  logic             sr_q,
  input  logic             sr_qn,
  input  logic             jk_q,
  input  logic             jk_qn,
  input  logic             d_q,
  input  logic             d_qn,
  output logic             err,
  output logic             err_pulse,
  output logic [2:0]       err_vec,
  output logic [CNT_W-1:0] sr_err_cnt,
  output logic [CNT_W-1:0] jk_err_cnt,
  output logic [CNT_W-1:0] d_err_cnt,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef struct packed {
    logic valid;
    logic sr_known;
    logic sr_inv;
    logic sr_exp;
    logic jk_known;
    logic jk_exp;
    logic d_exp;
  } entry_t;

  logic sr_known_q, sr_known_d, sr_inv_q, sr_inv_d, sr_exp_q, sr_exp_d;
  logic jk_known_q, jk_known_d, jk_exp_q, jk_exp_d;
  entry_t line_q [SETTLE_CYC];
  entry_t line_d [SETTLE_CYC];
  entry_t head;

  logic             sr_fail, jk_fail, d_fail;
  logic [2:0]       fail_vec;
  logic             err_q, err_d, err_pulse_q, err_pulse_d;
  logic [2:0]       err_vec_q, err_vec_d;
  logic [CNT_W-1:0] sr_cnt_q, sr_cnt_d, jk_cnt_q, jk_cnt_d;
  logic [CNT_W-1:0] d_cnt_q, d_cnt_d, smp_cnt_q, smp_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  // Reference model; the entry pushed carries the post-update state.
  always_comb begin
    sr_known_d = sr_known_q;
    sr_inv_d   = sr_inv_q;
    sr_exp_d   = sr_exp_q;
    jk_known_d = jk_known_q;
    jk_exp_d   = jk_exp_q;
    if (sample_en) begin
      unique case ({a, b})
        2'b10: begin
          sr_known_d = 1'b1; sr_inv_d = 1'b0; sr_exp_d = 1'b1;
          jk_known_d = 1'b1; jk_exp_d = 1'b1;
        end
        2'b01: begin
          sr_known_d = 1'b1; sr_inv_d = 1'b0; sr_exp_d = 1'b0;
          jk_known_d = 1'b1; jk_exp_d = 1'b0;
        end
        2'b11: begin
          sr_known_d = 1'b0; sr_inv_d = 1'b1;
          jk_exp_d   = ~jk_exp_q;
        end
        default: ;
      endcase
    end

    line_d[0] = '0;
    if (sample_en) begin
      line_d[0] = {1'b1, sr_known_d, sr_inv_d, sr_exp_d, jk_known_d, jk_exp_d, a};
    end
    for (int i = 1; i < SETTLE_CYC; i++) begin
      line_d[i] = line_q[i-1];
    end
    head = line_q[SETTLE_CYC-1];
  end

  // SR after an invalid 11 may legally show q == qn, so that check is waived there.
  always_comb begin
    sr_fail  = (head.sr_known && (sr_q != head.sr_exp)) || (!head.sr_inv && (sr_q == sr_qn));
    jk_fail  = (head.jk_known && (jk_q != head.jk_exp)) || (jk_q == jk_qn);
    d_fail   = (d_q != head.d_exp) || (d_q == d_qn);
    fail_vec = {d_fail, jk_fail, sr_fail};

    err_d       = err_q;
    err_pulse_d = 1'b0;
    err_vec_d   = err_vec_q;
    sr_cnt_d    = sr_cnt_q;
    jk_cnt_d    = jk_cnt_q;
    d_cnt_d     = d_cnt_q;
    smp_cnt_d   = smp_cnt_q;
    if (clear) begin
      err_d     = 1'b0;
      err_vec_d = 3'b000;
      sr_cnt_d  = '0;
      jk_cnt_d  = '0;
      d_cnt_d   = '0;
      smp_cnt_d = '0;
    end else if (head.valid) begin
      smp_cnt_d = sat_inc(smp_cnt_q);
      if (|fail_vec) begin
        err_pulse_d = 1'b1;
        err_d       = 1'b1;
        err_vec_d   = fail_vec;
        if (sr_fail) sr_cnt_d = sat_inc(sr_cnt_q);
        if (jk_fail) jk_cnt_d = sat_inc(jk_cnt_q);
        if (d_fail)  d_cnt_d  = sat_inc(d_cnt_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_known_q  <= 1'b0;
      sr_inv_q    <= 1'b0;
      sr_exp_q    <= 1'b0;
      jk_known_q  <= 1'b0;
      jk_exp_q    <= 1'b0;
      for (int i = 0; i < SETTLE_CYC; i++) line_q[i] <= '0;
      err_q       <= 1'b0;
      err_pulse_q <= 1'b0;
      err_vec_q   <= 3'b000;
      sr_cnt_q    <= '0;
      jk_cnt_q    <= '0;
      d_cnt_q     <= '0;
      smp_cnt_q   <= '0;
    end else begin
      sr_known_q  <= sr_known_d;
      sr_inv_q    <= sr_inv_d;
      sr_exp_q    <= sr_exp_d;
      jk_known_q  <= jk_known_d;
      jk_exp_q    <= jk_exp_d;
      for (int i = 0; i < SETTLE_CYC; i++) line_q[i] <= line_d[i];
      err_q       <= err_d;
      err_pulse_q <= err_pulse_d;
      err_vec_q   <= err_vec_d;
      sr_cnt_q    <= sr_cnt_d;
      jk_cnt_q    <= jk_cnt_d;
      d_cnt_q     <= d_cnt_d;
      smp_cnt_q   <= smp_cnt_d;
    end
  end

  assign err        = err_q;
  assign err_pulse  = err_pulse_q;
  assign err_vec    = err_vec_q;
  assign sr_err_cnt = sr_cnt_q;
  assign jk_err_cnt = jk_cnt_q;
  assign d_err_cnt  = d_cnt_q;
  assign sample_cnt = smp_cnt_q;

endmodule
